modbus_host_msg_buf: RTL and testbench
======================================

// Module: modbus_host_msg_buf
// PURPOSE
//  Host-side message buffer between the APB CSR message window and the UART bridge byte streams.
//  RX: bridge bytes and frame_end are buffered with an EOF tag for the CSR pop interface.
//  TX: host-pushed bytes are held, then released as one frame to the bridge on a go pulse.
//  Sits beside modbus_controller and replaces the tied-off csr_rx_*/csr_tx_ready wiring in the top.
// PARAMETERS
//  DEPTH    64  entries per FIFO (power of 2, >=4)
//  AW        6  log2(DEPTH); level outputs are AW+1 bits
// PORTS
//  PCLK            in   1     clock; one clock domain
//  PRESETn         in   1     reset, asynchronous assert, active-low
//  rx_b_i          in   8     byte from uart_bridge
//  rx_b_v_i        in   1     rx_b_i valid, single-cycle pulse
//  frame_end_i     in   1     bridge end-of-frame pulse
//  csr_rx_data_o   out  8     head byte of the RX FIFO
//  csr_rx_eof_o    out  1     head byte is the last byte of its frame
//  csr_rx_valid_o  out  1     RX FIFO not empty
//  csr_rx_pop_i    in   1     pop head; ignored when empty
//  csr_tx_data_i   in   8     host byte
//  csr_tx_push_i   in   1     push; ignored when full
//  csr_tx_ready_o  out  1     TX FIFO not full
//  tx_go_i         in   1     release the buffered TX frame
//  flush_i         in   1     sync clear of both FIFOs, counters and sticky bits
//  tx_b_o          out  8     byte to uart_bridge
//  tx_b_v_o        out  1     tx_b_o valid
//  tx_b_rdy_i      in   1     bridge accepts; transfer = tx_b_v_o & tx_b_rdy_i
//  cfg_msg_wm_i    in   16    RX watermark in bytes; 0 = disabled
//  rx_level_o      out  AW+1  RX occupancy
//  tx_level_o      out  AW+1  TX occupancy
//  rx_frames_o     out  8     completed RX frames not yet fully popped; saturates at 255
//  rx_ovf_o        out  1     sticky: RX byte dropped while full
//  tx_busy_o       out  1     TX FSM in SEND
//  wm_irq_o        out  1     level: (cfg_msg_wm_i!=0) & (rx_level_o >= cfg_msg_wm_i)
// BEHAVIOUR
//  Reset (PRESETn low, or flush_i): all outputs 0 except csr_tx_ready_o=0 in reset and 1 after;
//   pointers, levels, frames, ovf cleared; FSM=IDLE. Flush beats every other event that cycle.
//  RX write: rx_b_v_i & (~full | pop same cycle) writes {eof,byte}. eof = frame_end_i same cycle.
//   Byte dropped while full with no pop: rx_ovf_o <= 1 until flush/reset.
//  frame_end_i with no byte this cycle: set eof tag on the newest entry (wr_ptr-1). If the FIFO is empty, set no tag.
//   Every frame_end_i increments rx_frames_o (saturate).
//  RX pop: registered head; csr_rx_data/eof valid the same cycle as csr_rx_valid_o; pop updates next cycle.
//   Popping an entry with eof=1 decrements rx_frames_o (floor 0).
//  Simultaneous: full+write+pop -> both succeed, level unchanged; empty+write+pop -> pop ignored.
//  Pointers wrap modulo DEPTH; a full/empty flag or extra pointer bit resolves ptr equality.
//  TX FSM IDLE -> SEND on tx_go_i & tx_level!=0. Latch tx_len = tx_level_o at that edge.
//   tx_go_i with an empty FIFO, or during SEND, is ignored.
//  SEND: tx_b_v_o = 1, tx_b_o = head byte; each transfer pops and decrements tx_len.
//   When the last byte transfers (tx_len==1), go IDLE next cycle. Bytes pushed after go stay for the next frame.
//   Push during SEND is allowed if not full; push+pop same cycle when full succeeds.
//  tx_b_o/tx_b_v_o must stay stable while tx_b_v_o & ~tx_b_rdy_i.
//  Watermark compares zero-extended rx_level_o against 16 bits; wm_irq_o is combinational from registers.
// STRUCTURE
//  modbus_pkg: TX state enum (IDLE=1'b0, SEND=1'b1) and the default DEPTH constant.
//  One sub-module, sync_byte_fifo #(W,DEPTH). Instantiate it twice: W=9 for RX (eof tag), W=8 for TX.
//   It exposes rd/wr, level, full, empty, and a tag_set_last port (used by RX only).
// TESTING
//  Reset, then RX 3 bytes 01,03,A5 with frame_end on A5 -> level=3, frames=1; pops give eof 0,0,1; frames=0.
//  Frame_end one cycle after the last byte 7E (FIFO non-empty) -> 7E popped with eof=1.
//   Frame_end with an empty FIFO -> frames=1, no tag.
//  Fill RX to 64, write one more -> byte dropped, rx_ovf=1, level=64. Write+pop at full -> level stays 64.
//   flush -> level=0, ovf=0.
//  Push 8 TX bytes, then go; hold rdy low 5 cycles -> tx_b_v=1 and data stable.
//   Release rdy -> 8 transfers in order, then busy=0. Push 2 more during SEND -> only 8 sent, tx_level=2.
//  cfg_msg_wm=4: wm_irq rises on the 4th RX byte and falls after the pop to 3; wm=0 -> never asserts.
//  Assert PRESETn low mid-SEND -> tx_b_v=0 immediately, levels 0; after release csr_tx_ready=1 and FSM=IDLE.

Source files
------------

// File: rtl/modbus_pkg.sv
// Shared types for the modbus host message buffer.
// TX release state and default FIFO depth.
package modbus_pkg;

  localparam int DEPTH_DEF = 64;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_st_e;

endpackage

// File: rtl/modbus_host_msg_buf_fifo.sv
// Synchronous byte FIFO with level, full/empty
// and an in-place tag on the newest entry.
module sync_byte_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          wr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          rd_i,
  input  logic          tag_set_last_i,
  output logic [W-1:0]  rdata_o,
  output logic [AW:0]   level_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW-1:0] last_ptr;
  logic [AW:0]   level_q;
  logic          rd_ok, wr_ok;

  assign full_o   = (level_q == (AW+1)'(DEPTH));
  assign empty_o  = (level_q == '0);
  assign level_o  = level_q;
  assign rdata_o  = mem_q[rd_ptr_q];
  assign last_ptr = wr_ptr_q - AW'(1);

  // A full FIFO still takes a write when the head leaves that cycle.
  assign rd_ok = rd_i & ~empty_o;
  assign wr_ok = wr_i & (~full_o | rd_ok);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + (AW+1)'(wr_ok)
                         - (AW+1)'(rd_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clr_i) begin
      if (wr_ok)
        mem_q[wr_ptr_q] <= wdata_i;
      if (tag_set_last_i && !empty_o)
        mem_q[last_ptr][W-1] <= 1'b1;
    end
  end

endmodule

// File: rtl/modbus_host_msg_buf.sv
// Host message buffer: RX bytes with EOF tags for CSR pop,
// TX bytes held and released as one frame on go.
module modbus_host_msg_buf
  import modbus_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [7:0]  rx_b_i,
  input  logic        rx_b_v_i,
  input  logic        frame_end_i,
  output logic [7:0]  csr_rx_data_o,
  output logic        csr_rx_eof_o,
  output logic        csr_rx_valid_o,
  input  logic        csr_rx_pop_i,
  input  logic [7:0]  csr_tx_data_i,
  input  logic        csr_tx_push_i,
  output logic        csr_tx_ready_o,
  input  logic        tx_go_i,
  input  logic        flush_i,
  output logic [7:0]  tx_b_o,
  output logic        tx_b_v_o,
  input  logic        tx_b_rdy_i,
  input  logic [15:0] cfg_msg_wm_i,
  output logic [AW:0] rx_level_o,
  output logic [AW:0] tx_level_o,
  output logic [7:0]  rx_frames_o,
  output logic        rx_ovf_o,
  output logic        tx_busy_o,
  output logic        wm_irq_o
);

  logic [8:0]  rx_head;
  logic        rx_full, rx_empty;
  logic        rx_wr_ok, rx_pop_ok, rx_tag;
  logic [7:0]  tx_head;
  logic        tx_full, tx_empty, tx_xfer;

  tx_st_e      state_q;
  logic [AW:0] tx_len_q;
  logic [7:0]  frames_q;
  logic        ovf_q, rdy_q;
  logic        fr_inc, fr_dec;

  assign rx_tag    = frame_end_i & ~rx_b_v_i;
  assign rx_pop_ok = csr_rx_pop_i & ~rx_empty;
  assign rx_wr_ok  = rx_b_v_i & (~rx_full | rx_pop_ok);

  sync_byte_fifo #(.W(9), .DEPTH(DEPTH)) u_rx (
    .clk_i          (PCLK),
    .rst_ni         (PRESETn),
    .clr_i          (flush_i),
    .wr_i           (rx_b_v_i),
    .wdata_i        ({frame_end_i, rx_b_i}),
    .rd_i           (csr_rx_pop_i),
    .tag_set_last_i (rx_tag),
    .rdata_o        (rx_head),
    .level_o        (rx_level_o),
    .full_o         (rx_full),
    .empty_o        (rx_empty)
  );

  sync_byte_fifo #(.W(8), .DEPTH(DEPTH)) u_tx (
    .clk_i          (PCLK),
    .rst_ni         (PRESETn),
    .clr_i          (flush_i),
    .wr_i           (csr_tx_push_i),
    .wdata_i        (csr_tx_data_i),
    .rd_i           (tx_xfer),
    .tag_set_last_i (1'b0),
    .rdata_o        (tx_head),
    .level_o        (tx_level_o),
    .full_o         (tx_full),
    .empty_o        (tx_empty)
  );

  assign csr_rx_valid_o = ~rx_empty;
  assign csr_rx_data_o  = rx_empty ? 8'h00 : rx_head[7:0];
  assign csr_rx_eof_o   = ~rx_empty & rx_head[8];
  assign csr_tx_ready_o = rdy_q & ~tx_full;

  assign tx_b_v_o  = (state_q == SEND);
  assign tx_busy_o = (state_q == SEND);
  assign tx_b_o    = tx_b_v_o ? tx_head : 8'h00;
  assign tx_xfer   = tx_b_v_o & tx_b_rdy_i;

  assign rx_frames_o = frames_q;
  assign rx_ovf_o    = ovf_q;
  assign wm_irq_o    = (cfg_msg_wm_i != 16'h0) &&
                       (16'(rx_level_o) >= cfg_msg_wm_i);

  assign fr_inc = frame_end_i;
  assign fr_dec = rx_pop_ok & rx_head[8];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      frames_q <= '0;
      ovf_q    <= 1'b0;
    end else if (flush_i) begin
      frames_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (rx_b_v_i && !rx_wr_ok) ovf_q <= 1'b1;
      if (fr_inc && !fr_dec && frames_q != 8'hFF)
        frames_q <= frames_q + 8'd1;
      else if (fr_dec && !fr_inc && frames_q != 8'h00)
        frames_q <= frames_q - 8'd1;
    end
  end

  // tx_len counts only the bytes present at go; later pushes wait.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      tx_len_q <= '0;
      rdy_q    <= 1'b0;
    end else if (flush_i) begin
      state_q  <= IDLE;
      tx_len_q <= '0;
      rdy_q    <= 1'b1;
    end else begin
      rdy_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (tx_go_i && !tx_empty) begin
            state_q  <= SEND;
            tx_len_q <= tx_level_o;
          end
        end
        SEND: begin
          if (tx_xfer) begin
            tx_len_q <= tx_len_q - (AW+1)'(1);
            if (tx_len_q == (AW+1)'(1))
              state_q <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modbus_host_msg_buf.sv
// Bench for modbus_host_msg_buf: queue-based model checked
// every cycle, directed scenarios plus randomized traffic.
module tb_modbus_host_msg_buf;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic [7:0]  rx_b_i;
  logic        rx_b_v_i, frame_end_i, csr_rx_pop_i;
  logic [7:0]  csr_rx_data_o;
  logic        csr_rx_eof_o, csr_rx_valid_o;
  logic [7:0]  csr_tx_data_i;
  logic        csr_tx_push_i, csr_tx_ready_o;
  logic        tx_go_i, flush_i;
  logic [7:0]  tx_b_o;
  logic        tx_b_v_o, tx_b_rdy_i;
  logic [15:0] cfg_msg_wm_i;
  logic [AW:0] rx_level_o, tx_level_o;
  logic [7:0]  rx_frames_o;
  logic        rx_ovf_o, tx_busy_o, wm_irq_o;

  always #5 PCLK = ~PCLK;

  modbus_host_msg_buf #(.DEPTH(DEPTH)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .rx_b_i(rx_b_i), .rx_b_v_i(rx_b_v_i),
    .frame_end_i(frame_end_i),
    .csr_rx_data_o(csr_rx_data_o),
    .csr_rx_eof_o(csr_rx_eof_o),
    .csr_rx_valid_o(csr_rx_valid_o),
    .csr_rx_pop_i(csr_rx_pop_i),
    .csr_tx_data_i(csr_tx_data_i),
    .csr_tx_push_i(csr_tx_push_i),
    .csr_tx_ready_o(csr_tx_ready_o),
    .tx_go_i(tx_go_i), .flush_i(flush_i),
    .tx_b_o(tx_b_o), .tx_b_v_o(tx_b_v_o),
    .tx_b_rdy_i(tx_b_rdy_i),
    .cfg_msg_wm_i(cfg_msg_wm_i),
    .rx_level_o(rx_level_o), .tx_level_o(tx_level_o),
    .rx_frames_o(rx_frames_o), .rx_ovf_o(rx_ovf_o),
    .tx_busy_o(tx_busy_o), .wm_irq_o(wm_irq_o)
  );

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Behavioural model: RX entries {eof,byte}, TX bytes.
  logic [8:0] rxq[$];
  logic [7:0] txq[$];
  int m_frames, m_len;
  bit m_ovf, m_busy, m_rdy;

  always @(posedge PCLK) begin : model
    bit pop, wr, xfer, push;
    bit heof;
    int f;
    logic [8:0] tmp;
    if (!PRESETn || flush_i) begin
      rxq.delete(); txq.delete();
      m_frames = 0; m_len = 0;
      m_ovf = 0; m_busy = 0;
      m_rdy = PRESETn;
    end else begin
      m_rdy = 1;
      pop  = csr_rx_pop_i && rxq.size() > 0;
      heof = pop ? rxq[0][8] : 1'b0;
      wr   = rx_b_v_i && (rxq.size() < DEPTH || pop);
      if (frame_end_i && !rx_b_v_i && rxq.size() > 0) begin
        tmp = rxq[rxq.size()-1];
        tmp[8] = 1'b1;
        rxq[rxq.size()-1] = tmp;
      end
      if (pop) void'(rxq.pop_front());
      if (rx_b_v_i && !wr) m_ovf = 1;
      if (wr) rxq.push_back({frame_end_i, rx_b_i});
      f = m_frames + int'(frame_end_i) - int'(heof);
      m_frames = f < 0 ? 0 : (f > 255 ? 255 : f);
      xfer = m_busy && tx_b_rdy_i;
      push = csr_tx_push_i && (txq.size() < DEPTH || xfer);
      if (m_busy) begin
        if (xfer) begin
          void'(txq.pop_front());
          m_len--;
          if (m_len == 0) m_busy = 0;
        end
      end else if (tx_go_i && txq.size() > 0) begin
        m_busy = 1;
        m_len  = txq.size();
      end
      if (push) txq.push_back(csr_tx_data_i);
    end
  end

  always @(negedge PCLK) begin : compare
    bit rv;
    int lvl;
    if (PRESETn && chk_en) begin
      rv  = rxq.size() > 0;
      lvl = rxq.size();
      chk("rx_valid", csr_rx_valid_o, rv);
      chk("rx_data", csr_rx_data_o, rv ? rxq[0][7:0] : 8'h0);
      chk("rx_eof", csr_rx_eof_o, rv ? rxq[0][8] : 1'b0);
      chk("rx_level", rx_level_o, lvl);
      chk("tx_level", tx_level_o, txq.size());
      chk("rx_frames", rx_frames_o, m_frames);
      chk("rx_ovf", rx_ovf_o, m_ovf);
      chk("tx_ready", csr_tx_ready_o,
          m_rdy && txq.size() < DEPTH);
      chk("tx_busy", tx_busy_o, m_busy);
      chk("tx_v", tx_b_v_o, m_busy);
      chk("tx_b", tx_b_o, m_busy ? txq[0] : 8'h0);
      chk("wm_irq", wm_irq_o,
          cfg_msg_wm_i != 0 && lvl >= int'(cfg_msg_wm_i));
    end
  end

  task automatic tick();
    @(negedge PCLK);
    #2;
  endtask

  task automatic idle();
    rx_b_v_i = 0; frame_end_i = 0; csr_rx_pop_i = 0;
    csr_tx_push_i = 0; tx_go_i = 0; flush_i = 0;
  endtask

  task automatic do_flush();
    idle();
    flush_i = 1;
    tick();
    flush_i = 0;
  endtask

  initial begin
    int n;
    idle();
    rx_b_i = 0; csr_tx_data_i = 0;
    tx_b_rdy_i = 0; cfg_msg_wm_i = 0;
    repeat (3) tick();
    chk("rst_ready", csr_tx_ready_o, 0);
    chk("rst_txv", tx_b_v_o, 0);
    chk("rst_rxv", csr_rx_valid_o, 0);
    chk("rst_rxlvl", rx_level_o, 0);
    PRESETn = 1;
    chk_en  = 1;
    tick();
    chk("post_rst_ready", csr_tx_ready_o, 1);

    // three-byte frame, eof on the last byte
    rx_b_v_i = 1; rx_b_i = 8'h01; tick();
    rx_b_i = 8'h03; tick();
    rx_b_i = 8'hA5; frame_end_i = 1; tick();
    idle();
    chk("f3_level", rx_level_o, 3);
    chk("f3_frames", rx_frames_o, 1);
    csr_rx_pop_i = 1;
    chk("pop0_d", csr_rx_data_o, 8'h01);
    chk("pop0_e", csr_rx_eof_o, 0);
    tick();
    chk("pop1_d", csr_rx_data_o, 8'h03);
    chk("pop1_e", csr_rx_eof_o, 0);
    tick();
    chk("pop2_d", csr_rx_data_o, 8'hA5);
    chk("pop2_e", csr_rx_eof_o, 1);
    tick();
    idle();
    chk("f3_frames0", rx_frames_o, 0);
    chk("f3_empty", rx_level_o, 0);

    // late frame_end tags the newest byte
    rx_b_v_i = 1; rx_b_i = 8'h7E; tick();
    idle(); frame_end_i = 1; tick();
    idle();
    chk("late_d", csr_rx_data_o, 8'h7E);
    chk("late_e", csr_rx_eof_o, 1);
    chk("late_fr", rx_frames_o, 1);
    csr_rx_pop_i = 1; tick(); idle();
    chk("late_fr0", rx_frames_o, 0);
    frame_end_i = 1; tick(); idle();
    chk("empty_fe_fr", rx_frames_o, 1);
    chk("empty_fe_v", csr_rx_valid_o, 0);
    do_flush();

    // fill, overflow, write+pop at full, flush
    rx_b_v_i = 1;
    for (int i = 0; i < DEPTH; i++) begin
      rx_b_i = 8'(i); tick();
    end
    rx_b_i = 8'hFF; tick();
    idle();
    chk("ovf_set", rx_ovf_o, 1);
    chk("ovf_lvl", rx_level_o, DEPTH);
    rx_b_v_i = 1; csr_rx_pop_i = 1; rx_b_i = 8'h55;
    tick(); idle();
    chk("full_wp_lvl", rx_level_o, DEPTH);
    chk("full_wp_d", csr_rx_data_o, 8'h01);
    do_flush();
    chk("flush_lvl", rx_level_o, 0);
    chk("flush_ovf", rx_ovf_o, 0);

    // TX frame with backpressure
    csr_tx_push_i = 1;
    for (int i = 0; i < 8; i++) begin
      csr_tx_data_i = 8'h10 + 8'(i); tick();
    end
    idle();
    tx_b_rdy_i = 0;
    tx_go_i = 1; tick(); idle();
    for (int i = 0; i < 5; i++) begin
      chk("hold_v", tx_b_v_o, 1);
      chk("hold_d", tx_b_o, 8'h10);
      csr_tx_push_i = (i < 2);
      csr_tx_data_i = 8'hA0 + 8'(i);
      tick();
    end
    idle();
    tx_b_rdy_i = 1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (tx_b_v_o) begin
        chk("tx_order", tx_b_o, 8'h10 + 8'(n));
        n++;
      end
      tick();
    end
    chk("tx_count", n, 8);
    chk("tx_idle", tx_busy_o, 0);
    chk("tx_left", tx_level_o, 2);
    tx_go_i = 1; tick(); idle();
    repeat (4) tick();
    chk("tx_drain", tx_level_o, 0);
    tx_b_rdy_i = 0;

    // watermark
    cfg_msg_wm_i = 16'd4;
    for (int i = 0; i < 4; i++) begin
      rx_b_v_i = 1; rx_b_i = 8'(i); tick(); idle();
      chk("wm_rise", wm_irq_o, i == 3);
    end
    csr_rx_pop_i = 1; tick(); idle();
    chk("wm_fall", wm_irq_o, 0);
    cfg_msg_wm_i = 16'd0;
    rx_b_v_i = 1; tick(); tick(); idle();
    chk("wm_off", wm_irq_o, 0);
    do_flush();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int hi;
      hi = (i / 500) % 2;
      rx_b_v_i      = $urandom_range(0, 1);
      rx_b_i        = 8'($urandom);
      frame_end_i   = ($urandom % 8) == 0;
      csr_rx_pop_i  = ($urandom % 10) < (hi ? 7 : 2);
      csr_tx_push_i = ($urandom % 10) < (hi ? 2 : 6);
      csr_tx_data_i = 8'($urandom);
      tx_go_i       = ($urandom % 12) == 0;
      tx_b_rdy_i    = ($urandom % 10) < (hi ? 8 : 3);
      flush_i       = ($urandom % 600) == 0;
      if ($urandom % 50 == 0)
        cfg_msg_wm_i = 16'($urandom_range(0, 70));
      tick();
    end
    idle();
    tx_b_rdy_i = 0;
    do_flush();

    // async reset in the middle of SEND
    csr_tx_push_i = 1;
    for (int i = 0; i < 8; i++) begin
      csr_tx_data_i = 8'(i); tick();
    end
    idle();
    tx_go_i = 1; tick(); idle();
    tick();
    chk("mid_send_v", tx_b_v_o, 1);
    PRESETn = 0;
    #1;
    chk("arst_v", tx_b_v_o, 0);
    chk("arst_txl", tx_level_o, 0);
    chk("arst_rxl", rx_level_o, 0);
    chk("arst_rdy", csr_tx_ready_o, 0);
    tick(); tick();
    PRESETn = 1;
    tick();
    chk("rel_rdy", csr_tx_ready_o, 1);
    chk("rel_busy", tx_busy_o, 0);
    chk("rel_v", tx_b_v_o, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
